// File: rtl/mmcam_fire_packer_pkg.sv
// mmcam_fire_packer_pkg
// Shared definitions for the MMCAM read-side fire packer:
//   - default MMCAM field widths and entry count
//   - operand side encoding (LR_LEFT / LR_RIGHT)
//   - packer FSM state encoding
// No ports (package).
package mmcam_fire_packer_pkg;

  localparam int MMCAM_ENTRIES   = 8;
  localparam int MMCAM_CGD_W     = 16;
  localparam int MMCAM_DATA_W    = 16;
  localparam int PAIR_FIFO_DEPTH = 2;

  // Side of an incoming token within its instruction's operand pair.
  localparam logic LR_LEFT  = 1'b0;
  localparam logic LR_RIGHT = 1'b1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_READ = 1'b1
  } fsm_state_e;

endpackage

// File: rtl/mmcam_pair_fifo.sv
// mmcam_pair_fifo
// Small synchronous FIFO holding assembled operand-pair packets.
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   push, push_data   write request and packet; ignored when full unless popping
//   pop               read request; ignored when empty
//   head_data         oldest entry, held stable until popped
//   count             number of stored entries (0..DEPTH)
module mmcam_pair_fifo #(
  parameter  int DATA_W = 48,
  parameter  int DEPTH  = 2,
  localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head_data,
  output logic [CNT_W-1:0]  count
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              do_push_s, do_pop_s;

  // Pointers wrap modulo DEPTH, so DEPTH need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Next-state for pointers and occupancy; a full FIFO may still push when popping.
  always_comb begin
    do_pop_s  = pop && (count_q != '0);
    do_push_s = push && ((count_q != CNT_W'(DEPTH)) || do_pop_s);
    wr_ptr_d  = do_push_s ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d  = do_pop_s ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    case ({do_push_s, do_pop_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage and pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push_s) begin
        mem_q[wr_ptr_q] <= push_data;
      end
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head_data = mem_q[rd_ptr_q];
  assign count     = count_q;

endmodule

// File: rtl/mmcam_fire_packer.sv
// mmcam_fire_packer
// Read-side companion of the MMCAM entry array. A token that misses is handed to
// the MMCAM via STORE; a token that hits has its partner operand read from the
// hit entry (RD_IDX / RD_DATA) one cycle later, the entry is released with a
// one-hot CLR pulse, and an ordered {CGD, left, right} packet is queued for the
// firing stage.
// Ports:
//   CP, MR_N                      clock, asynchronous active-low reset
//   IN_REQ/IN_ACK                 token handshake; IN_CGD, IN_LR, IN_DATA token fields
//   HIT                           per-entry FIRE vector, valid with IN_*
//   STORE                         MMCAM write enable for a missing token (combinational)
//   RD_IDX / RD_DATA              partner read port (combinational read by the MMCAM)
//   CLR                           one-hot release of the consumed entry
//   OUT_REQ/OUT_ACK               packet handshake; OUT_CGD, OUT_L, OUT_R packet fields
//   HIT_ERR                       sticky flag: a multi-hot HIT was accepted
module mmcam_fire_packer
  import mmcam_fire_packer_pkg::*;
#(
  parameter  int ENTRIES    = MMCAM_ENTRIES,
  parameter  int CGD_W      = MMCAM_CGD_W,
  parameter  int DATA_W     = MMCAM_DATA_W,
  parameter  int FIFO_DEPTH = PAIR_FIFO_DEPTH,
  localparam int IDX_W      = (ENTRIES > 1) ? $clog2(ENTRIES) : 1
) (
  input  logic               CP,
  input  logic               MR_N,
  input  logic               IN_REQ,
  output logic               IN_ACK,
  input  logic [CGD_W-1:0]   IN_CGD,
  input  logic               IN_LR,
  input  logic [DATA_W-1:0]  IN_DATA,
  input  logic [ENTRIES-1:0] HIT,
  output logic               STORE,
  output logic [IDX_W-1:0]   RD_IDX,
  input  logic [DATA_W-1:0]  RD_DATA,
  output logic [ENTRIES-1:0] CLR,
  output logic               OUT_REQ,
  input  logic               OUT_ACK,
  output logic [CGD_W-1:0]   OUT_CGD,
  output logic [DATA_W-1:0]  OUT_L,
  output logic [DATA_W-1:0]  OUT_R,
  output logic               HIT_ERR
);

  localparam int PAIR_W = CGD_W + 2 * DATA_W;
  localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);

  fsm_state_e         state_q, state_d;
  logic [CGD_W-1:0]   cgd_q, cgd_d;
  logic               lr_q, lr_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic [IDX_W-1:0]   rd_idx_q, rd_idx_d;
  logic [ENTRIES-1:0] clr_q, clr_d;
  logic               hit_err_q, hit_err_d;

  logic [IDX_W-1:0]   hit_idx_s;
  logic               hit_any_s;
  logic               multi_hot_s;
  logic               accept_s;
  logic               push_s;
  logic [PAIR_W-1:0]  push_data_s;
  logic [PAIR_W-1:0]  head_s;
  logic [CNT_W-1:0]   fifo_count_s;

  // Lowest-index priority encode of HIT; scanning downward lets the lowest set bit win.
  always_comb begin
    hit_idx_s = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      hit_idx_s = HIT[i] ? IDX_W'(i) : hit_idx_s;
    end
    hit_any_s   = (HIT != '0);
    multi_hot_s = ((HIT & (HIT - ENTRIES'(1))) != '0);
  end

  // Only IDLE accepts, and only with a free FIFO slot, so the READ push can never overflow.
  assign IN_ACK   = MR_N && (state_q == ST_IDLE) && (fifo_count_s < CNT_W'(FIFO_DEPTH));
  assign accept_s = IN_REQ && IN_ACK;
  assign STORE    = accept_s && !hit_any_s;

  // FSM next-state: a hit latches the token and schedules the one-cycle READ with its CLR pulse.
  always_comb begin
    state_d   = state_q;
    cgd_d     = cgd_q;
    lr_d      = lr_q;
    data_d    = data_q;
    rd_idx_d  = rd_idx_q;
    clr_d     = '0;
    hit_err_d = hit_err_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s && hit_any_s) begin
          state_d   = ST_READ;
          cgd_d     = IN_CGD;
          lr_d      = IN_LR;
          data_d    = IN_DATA;
          rd_idx_d  = hit_idx_s;
          clr_d     = ENTRIES'(1) << hit_idx_s;
          hit_err_d = hit_err_q | multi_hot_s;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_READ: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM and token latch registers; CLR is registered so it is high exactly during READ.
  always_ff @(posedge CP or negedge MR_N) begin
    if (!MR_N) begin
      state_q   <= ST_IDLE;
      cgd_q     <= '0;
      lr_q      <= LR_LEFT;
      data_q    <= '0;
      rd_idx_q  <= '0;
      clr_q     <= '0;
      hit_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cgd_q     <= cgd_d;
      lr_q      <= lr_d;
      data_q    <= data_d;
      rd_idx_q  <= rd_idx_d;
      clr_q     <= clr_d;
      hit_err_q <= hit_err_d;
    end
  end

  // Order the pair by the latched token side: a left token keeps its data on the left.
  always_comb begin
    push_s = (state_q == ST_READ);
    if (lr_q == LR_LEFT) begin
      push_data_s = {cgd_q, data_q, RD_DATA};
    end else begin
      push_data_s = {cgd_q, RD_DATA, data_q};
    end
  end

  mmcam_pair_fifo #(
    .DATA_W (PAIR_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_pair_fifo (
    .clk       (CP),
    .rst_n     (MR_N),
    .push      (push_s),
    .push_data (push_data_s),
    .pop       (OUT_ACK),
    .head_data (head_s),
    .count     (fifo_count_s)
  );

  assign OUT_REQ                = (fifo_count_s != '0);
  assign {OUT_CGD, OUT_L, OUT_R} = head_s;
  assign RD_IDX                 = rd_idx_q;
  assign CLR                    = clr_q;
  assign HIT_ERR                = hit_err_q;

endmodule

// File: tb/tb_mmcam_fire_packer.sv
// tb_mmcam_fire_packer
// Self-checking bench: a table of single-token vectors, hand-written sequences for
// backpressure and reset during READ, then randomized traffic checked against a
// queue-based packet model.
module tb_mmcam_fire_packer;

  localparam int EN = 8;
  localparam int CW = 16;
  localparam int DW = 16;
  localparam int IW = 3;

  logic          CP = 1'b0;
  logic          MR_N;
  logic          IN_REQ;
  logic          IN_ACK;
  logic [CW-1:0] IN_CGD;
  logic          IN_LR;
  logic [DW-1:0] IN_DATA;
  logic [EN-1:0] HIT;
  logic          STORE;
  logic [IW-1:0] RD_IDX;
  logic [DW-1:0] RD_DATA;
  logic [EN-1:0] CLR;
  logic          OUT_REQ;
  logic          OUT_ACK;
  logic [CW-1:0] OUT_CGD;
  logic [DW-1:0] OUT_L;
  logic [DW-1:0] OUT_R;
  logic          HIT_ERR;

  // Stored operands of the emulated MMCAM, read combinationally by index.
  logic [DW-1:0] cam_data [EN];
  assign RD_DATA = cam_data[RD_IDX];

  mmcam_fire_packer dut (
    .CP(CP), .MR_N(MR_N), .IN_REQ(IN_REQ), .IN_ACK(IN_ACK), .IN_CGD(IN_CGD),
    .IN_LR(IN_LR), .IN_DATA(IN_DATA), .HIT(HIT), .STORE(STORE), .RD_IDX(RD_IDX),
    .RD_DATA(RD_DATA), .CLR(CLR), .OUT_REQ(OUT_REQ), .OUT_ACK(OUT_ACK),
    .OUT_CGD(OUT_CGD), .OUT_L(OUT_L), .OUT_R(OUT_R), .HIT_ERR(HIT_ERR)
  );

  always #5 CP = ~CP;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic chk_pkt(input string name, input logic [CW-1:0] c,
                         input logic [DW-1:0] l, input logic [DW-1:0] r);
    chk({name, "_req"}, 64'(OUT_REQ), 64'(1'b1));
    chk({name, "_cgd"}, 64'(OUT_CGD), 64'(c));
    chk({name, "_l"},   64'(OUT_L),   64'(l));
    chk({name, "_r"},   64'(OUT_R),   64'(r));
  endtask

  task automatic tick();
    @(posedge CP);
    #1;
  endtask

  task automatic drive(input logic req, input logic [EN-1:0] h, input logic lr,
                       input logic [DW-1:0] d, input logic [CW-1:0] c);
    IN_REQ  = req;
    HIT     = h;
    IN_LR   = lr;
    IN_DATA = d;
    IN_CGD  = c;
  endtask

  typedef struct {
    logic [EN-1:0] hit;
    logic          lr;
    logic [DW-1:0] data;
    logic [CW-1:0] cgd;
    logic [DW-1:0] rd;
    logic [IW-1:0] idx;
    logic [DW-1:0] l;
    logic [DW-1:0] r;
    logic          err;
  } vec_t;

  typedef struct {
    logic [CW-1:0] cgd;
    logic [DW-1:0] l;
    logic [DW-1:0] r;
  } pkt_t;

  vec_t vt [7];

  // Reference helpers written from the rules, not from the RTL structure.
  function automatic int lowest_set(input logic [EN-1:0] v);
    for (int i = 0; i < EN; i++) begin
      if (v[i]) return i;
    end
    return 0;
  endfunction

  initial begin
    logic [EN-1:0] oh;
    pkt_t          q[$];
    pkt_t          pend;
    logic          busy;
    logic [IW-1:0] pend_idx;
    logic [EN-1:0] clr_exp;
    logic          err_m;
    logic          exp_ack;
    int            r;

    vt[0] = '{hit:8'h00, lr:1'b0, data:16'h1111, cgd:16'h0012, rd:16'h0000, idx:3'd0, l:16'h0000, r:16'h0000, err:1'b0};
    vt[1] = '{hit:8'h04, lr:1'b1, data:16'h0005, cgd:16'h0012, rd:16'h0003, idx:3'd2, l:16'h0003, r:16'h0005, err:1'b0};
    vt[2] = '{hit:8'h01, lr:1'b0, data:16'hAAAA, cgd:16'h0345, rd:16'h5555, idx:3'd0, l:16'hAAAA, r:16'h5555, err:1'b0};
    vt[3] = '{hit:8'h80, lr:1'b1, data:16'h0102, cgd:16'hBEEF, rd:16'hF00D, idx:3'd7, l:16'hF00D, r:16'h0102, err:1'b0};
    vt[4] = '{hit:8'h00, lr:1'b1, data:16'h2222, cgd:16'h0777, rd:16'h0000, idx:3'd0, l:16'h0000, r:16'h0000, err:1'b0};
    vt[5] = '{hit:8'hA0, lr:1'b0, data:16'h7777, cgd:16'h0ABC, rd:16'h1234, idx:3'd5, l:16'h7777, r:16'h1234, err:1'b1};
    vt[6] = '{hit:8'h10, lr:1'b0, data:16'h4242, cgd:16'h0001, rd:16'h9999, idx:3'd4, l:16'h4242, r:16'h9999, err:1'b1};

    for (int i = 0; i < EN; i++) cam_data[i] = 16'hD000 + DW'(i);

    // Reset with a token pending.
    MR_N    = 1'b0;
    OUT_ACK = 1'b0;
    drive(1'b1, 8'h00, 1'b0, 16'h0000, 16'h0000);
    tick();
    tick();
    chk("rst_in_ack",  64'(IN_ACK),  64'(1'b0));
    chk("rst_store",   64'(STORE),   64'(1'b0));
    chk("rst_clr",     64'(CLR),     64'(8'h00));
    chk("rst_out_req", 64'(OUT_REQ), 64'(1'b0));
    chk("rst_hit_err", 64'(HIT_ERR), 64'(1'b0));
    chk("rst_rd_idx",  64'(RD_IDX),  64'(3'd0));
    MR_N   = 1'b1;
    IN_REQ = 1'b0;
    #1;
    chk("rel_in_ack", 64'(IN_ACK), 64'(1'b1));
    tick();

    // Table of single tokens, consumer always ready.
    for (int i = 0; i < 7; i++) begin
      for (int k = 0; k < EN; k++) cam_data[k] = 16'hD000 + DW'(k);
      cam_data[vt[i].idx] = vt[i].rd;
      oh = '0;
      oh[vt[i].idx] = 1'b1;
      OUT_ACK = 1'b1;
      drive(1'b1, vt[i].hit, vt[i].lr, vt[i].data, vt[i].cgd);
      #1;
      chk($sformatf("v%0d_in_ack", i), 64'(IN_ACK), 64'(1'b1));
      chk($sformatf("v%0d_store", i),  64'(STORE),  64'(vt[i].hit == 8'h00));
      chk($sformatf("v%0d_clr0", i),   64'(CLR),    64'(8'h00));
      tick();
      drive(1'b0, 8'h00, 1'b0, 16'h0000, 16'h0000);
      #1;
      chk($sformatf("v%0d_hit_err", i), 64'(HIT_ERR), 64'(vt[i].err));
      chk($sformatf("v%0d_store_off", i), 64'(STORE), 64'(1'b0));
      if (vt[i].hit == 8'h00) begin
        chk($sformatf("v%0d_no_pkt", i), 64'(OUT_REQ), 64'(1'b0));
        chk($sformatf("v%0d_no_clr", i), 64'(CLR),     64'(8'h00));
      end else begin
        chk($sformatf("v%0d_rd_idx", i),   64'(RD_IDX),  64'(vt[i].idx));
        chk($sformatf("v%0d_clr", i),      64'(CLR),     64'(oh));
        chk($sformatf("v%0d_busy_ack", i), 64'(IN_ACK),  64'(1'b0));
        chk($sformatf("v%0d_req_early", i), 64'(OUT_REQ), 64'(1'b0));
        tick();
        chk($sformatf("v%0d_clr_done", i), 64'(CLR), 64'(8'h00));
        chk_pkt($sformatf("v%0d_pkt", i), vt[i].cgd, vt[i].l, vt[i].r);
        tick();
        chk($sformatf("v%0d_popped", i), 64'(OUT_REQ), 64'(1'b0));
      end
    end

    // Backpressure: two packets fill the buffer, the third token is refused.
    cam_data[1] = 16'h1001;
    cam_data[3] = 16'h3003;
    cam_data[6] = 16'h6006;
    OUT_ACK = 1'b0;
    drive(1'b1, 8'h02, 1'b0, 16'h0A01, 16'h0101);
    #1;
    chk("bp1_ack", 64'(IN_ACK), 64'(1'b1));
    tick();
    IN_REQ = 1'b0;
    tick();
    drive(1'b1, 8'h08, 1'b1, 16'h0A02, 16'h0202);
    #1;
    chk("bp2_ack", 64'(IN_ACK), 64'(1'b1));
    chk_pkt("bp_head1", 16'h0101, 16'h0A01, 16'h1001);
    tick();
    IN_REQ = 1'b0;
    tick();
    drive(1'b1, 8'h40, 1'b0, 16'h0A03, 16'h0303);
    #1;
    chk("bp3_full_ack", 64'(IN_ACK), 64'(1'b0));
    chk("bp3_store",    64'(STORE),  64'(1'b0));
    tick();
    chk("bp3_still_full", 64'(IN_ACK), 64'(1'b0));
    chk("bp3_no_clr",     64'(CLR),    64'(8'h00));
    chk_pkt("bp_hold1", 16'h0101, 16'h0A01, 16'h1001);
    IN_REQ  = 1'b0;
    OUT_ACK = 1'b1;
    tick();
    chk_pkt("bp_head2", 16'h0202, 16'h3003, 16'h0A02);
    chk("bp_ack_back", 64'(IN_ACK), 64'(1'b1));
    tick();
    chk("bp_drained", 64'(OUT_REQ), 64'(1'b0));

    // Reset while in READ drops the pair and the release pulse.
    cam_data[2] = 16'h0BAD;
    drive(1'b1, 8'h04, 1'b0, 16'h0C0C, 16'h0404);
    tick();
    IN_REQ = 1'b0;
    chk("mr_clr_before", 64'(CLR), 64'(8'h04));
    MR_N = 1'b0;
    #1;
    chk("mr_clr",     64'(CLR),     64'(8'h00));
    chk("mr_out_req", 64'(OUT_REQ), 64'(1'b0));
    chk("mr_in_ack",  64'(IN_ACK),  64'(1'b0));
    chk("mr_hit_err", 64'(HIT_ERR), 64'(1'b0));
    tick();
    tick();
    MR_N = 1'b1;
    #1;
    chk("mr_rel_ack", 64'(IN_ACK), 64'(1'b1));
    tick();
    chk("mr_no_pkt1", 64'(OUT_REQ), 64'(1'b0));
    tick();
    chk("mr_no_pkt2", 64'(OUT_REQ), 64'(1'b0));

    // Randomized traffic against the packet model.
    for (int i = 0; i < EN; i++) cam_data[i] = DW'($urandom);
    busy     = 1'b0;
    pend_idx = '0;
    pend     = '{cgd:'0, l:'0, r:'0};
    clr_exp  = '0;
    err_m    = 1'b0;
    for (int cyc = 0; cyc < 800; cyc++) begin
      IN_REQ  = ($urandom_range(0, 3) != 0);
      r       = $urandom_range(0, 9);
      HIT     = '0;
      if (r < 4) HIT = '0;
      else if (r < 9) HIT[$urandom_range(0, EN - 1)] = 1'b1;
      else HIT = EN'($urandom_range(1, 255));
      IN_LR   = $urandom_range(0, 1) != 0;
      IN_DATA = DW'($urandom);
      IN_CGD  = CW'($urandom);
      OUT_ACK = ($urandom_range(0, 2) != 0);
      #1;
      exp_ack = !busy && (q.size() < 2);
      chk("rnd_in_ack",  64'(IN_ACK),  64'(exp_ack));
      chk("rnd_store",   64'(STORE),   64'(IN_REQ && exp_ack && (HIT == '0)));
      chk("rnd_clr",     64'(CLR),     64'(clr_exp));
      chk("rnd_out_req", 64'(OUT_REQ), 64'(q.size() != 0));
      chk("rnd_hit_err", 64'(HIT_ERR), 64'(err_m));
      if (busy) chk("rnd_rd_idx", 64'(RD_IDX), 64'(pend_idx));
      if (q.size() != 0) chk_pkt("rnd_pkt", q[0].cgd, q[0].l, q[0].r);
      // Model update for the coming edge: pop, then the READ push, then a new hit.
      if (OUT_ACK && (q.size() != 0)) void'(q.pop_front());
      if (busy) q.push_back(pend);
      clr_exp = '0;
      busy    = 1'b0;
      if (IN_REQ && exp_ack && (HIT != '0)) begin
        busy     = 1'b1;
        pend_idx = IW'(lowest_set(HIT));
        clr_exp[pend_idx] = 1'b1;
        if (IN_LR == 1'b0) pend = '{cgd:IN_CGD, l:IN_DATA, r:cam_data[pend_idx]};
        else               pend = '{cgd:IN_CGD, l:cam_data[pend_idx], r:IN_DATA};
        if ($countones(HIT) > 1) err_m = 1'b1;
      end
      @(posedge CP);
      #1;
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
